// File: rtl/adc_capture_pkg.sv
// Shared types for the multi-channel ADC capture block.
// Capture FSM states and mode encodings.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } state_t;

  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_TRIG = 1'b1;

endpackage

// File: rtl/adc_sample_fifo.sv
// Per-channel synchronous sample FIFO.
// Show-ahead read data; writes while full are ignored.
module adc_sample_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           level
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wp_q;
  logic [AW-1:0]         rp_q;
  logic [AW:0]           cnt_q;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rd_data = mem_q[rp_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_wr}
                     - {{AW{1'b0}}, do_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: rtl/adc_multi_ch_capture.sv
// Multi-channel ADC capture: averaging, per-channel FIFOs,
// round-robin merge into one tagged ready/valid stream.
module adc_multi_ch_capture
  import adc_capture_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 12,
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_AVG_LOG2 = 4,
  parameter int CNT_W        = 16,
  localparam int KW   = $clog2(MAX_AVG_LOG2+1),
  localparam int CH_W = (NUM_CHANNELS > 1) ?
                        $clog2(NUM_CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHANNELS-1:0]          cfg_ch_en,
  input  logic                             cfg_mode,
  input  logic [KW-1:0]                    cfg_avg_log2,
  input  logic [CNT_W-1:0]                 cfg_cap_len,
  input  logic                             arm,
  input  logic                             trigger,
  input  logic                             stop,
  input  logic                             in_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CH_W-1:0]                  out_ch,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_CHANNELS-1:0]          overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = DATA_WIDTH + MAX_AVG_LOG2;
  localparam int NC    = NUM_CHANNELS;

  state_t               state_q, state_d;
  logic [NC-1:0]        en_q;
  logic                 mode_q;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        k_clamp;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     frm_q;
  logic [MAX_AVG_LOG2:0] avg_q;
  logic [MAX_AVG_LOG2:0] avg_mask;
  logic [NC-1:0]        ovf_q;
  logic                 done_q;

  logic                 arm_go;
  logic                 degen;
  logic                 accept;
  logic                 complete;
  logic                 last_frm;
  logic [NC-1:0]        wr_req;
  logic [NC-1:0]        full;
  logic [NC-1:0]        empty;
  logic [NC-1:0]        pop;
  logic [NC-1:0]        req;
  logic [NC-1:0]        onehot;
  logic [NC-1:0][DATA_WIDTH-1:0] dout;
  logic [NC-1:0][AW:0]  lvl;

  logic                 load;
  logic                 gnt_vld;
  logic [CH_W-1:0]      gnt;
  logic                 is_last;
  logic [CH_W-1:0]      last_q;
  logic                 out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CH_W-1:0]      out_ch_q;
  logic                 out_last_q;

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

  assign k_clamp = (cfg_avg_log2 > KW'(MAX_AVG_LOG2)) ?
                   KW'(MAX_AVG_LOG2) : cfg_avg_log2;
  assign avg_mask = ({{MAX_AVG_LOG2{1'b0}}, 1'b1} << k_q)
                    - 1'b1;

  // Empty mask or zero-length triggered capture: nothing to do.
  assign arm_go   = (state_q == IDLE) && arm;
  assign degen    = (en_q == '0) ||
                    ((mode_q == MODE_TRIG) && (len_q == '0));
  assign accept   = in_valid && !degen &&
                    ((state_q == CAPTURE) ||
                     ((state_q == ARMED) && trigger));
  assign complete = (avg_q == avg_mask);
  assign last_frm = (mode_q == MODE_TRIG) && accept && complete &&
                    ((frm_q + CNT_W'(1)) == len_q);
  assign wr_req   = en_q & {NC{accept && complete}};

  for (genvar i = 0; i < NC; i++) begin : g_ch
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      sum;
    logic [DATA_WIDTH-1:0] res;

    assign sum = acc_q +
                 ACC_W'(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
    assign res = DATA_WIDTH'(sum >> k_q);

    always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else if (arm_go) acc_q <= '0;
      else if (accept) acc_q <= complete ? '0 : sum;
    end

    adc_sample_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_req[i]),
      .wr_data(res),
      .rd_en  (pop[i]),
      .rd_data(dout[i]),
      .full   (full[i]),
      .empty  (empty[i]),
      .level  (lvl[i])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (arm)
          state_d = (cfg_mode == MODE_TRIG) ? ARMED : CAPTURE;
      ARMED:
        if (degen) state_d = DRAIN;
        else if (trigger) state_d = last_frm ? DRAIN : CAPTURE;
      CAPTURE:
        if (degen || last_frm ||
            ((mode_q == MODE_FREE) && stop))
          state_d = DRAIN;
      DRAIN:
        if ((&empty) && !out_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= '0;
      mode_q  <= MODE_FREE;
      k_q     <= '0;
      len_q   <= '0;
      frm_q   <= '0;
      avg_q   <= '0;
      ovf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);
      if (arm_go) begin
        en_q   <= cfg_ch_en;
        mode_q <= cfg_mode;
        k_q    <= k_clamp;
        len_q  <= cfg_cap_len;
        frm_q  <= '0;
        avg_q  <= '0;
        ovf_q  <= '0;
      end else begin
        if (accept) avg_q <= complete ? '0 : avg_q + 1'b1;
        if (accept && complete) frm_q <= frm_q + 1'b1;
        ovf_q <= ovf_q | (wr_req & full);
      end
    end
  end

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    req     = en_q & ~empty;
    gnt_vld = 1'b0;
    gnt     = last_q;
    for (int off = 1; off <= NC; off++) begin
      if (!gnt_vld && req[(int'(last_q) + off) % NC]) begin
        gnt_vld = 1'b1;
        gnt     = CH_W'((int'(last_q) + off) % NC);
      end
    end
  end

  assign load   = !out_valid_q || out_ready;
  assign onehot = NC'(1) << gnt;
  assign pop    = {NC{load && gnt_vld}} & onehot;
  assign is_last = (state_d == DRAIN) && (wr_req == '0) &&
                   (~empty == onehot) &&
                   (lvl[gnt] == (AW+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      last_q      <= CH_W'(NC-1);
    end else begin
      if (arm_go) last_q <= CH_W'(NC-1);
      if (load && gnt_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= dout[gnt];
        out_ch_q    <= gnt;
        out_last_q  <= is_last;
        last_q      <= gnt;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_multi_ch_capture.sv
// Scoreboard bench for adc_multi_ch_capture.
// Directed captures with hand-computed expected words.
module tb_adc_multi_ch_capture;

  localparam int N   = 4;
  localparam int DW  = 12;
  localparam int CW  = 16;
  localparam int KW  = 3;
  localparam int CHW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cfg_ch_en;
  logic            cfg_mode;
  logic [KW-1:0]   cfg_avg_log2;
  logic [CW-1:0]   cfg_cap_len;
  logic            arm, trigger, stop, in_valid;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_ready, out_last;
  logic [DW-1:0]   out_data;
  logic [CHW-1:0]  out_ch;
  logic            busy, done;
  logic [N-1:0]    overflow;

  adc_multi_ch_capture #(
    .NUM_CHANNELS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(16),
    .MAX_AVG_LOG2(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_ch_en(cfg_ch_en),
    .cfg_mode(cfg_mode), .cfg_avg_log2(cfg_avg_log2),
    .cfg_cap_len(cfg_cap_len), .arm(arm),
    .trigger(trigger), .stop(stop),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
    logic           last;
  } word_t;

  word_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_out_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    word_t w;
    if (!rst && out_valid && out_ready) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word: unexpected ch=%0d data=%h last=%0b",
                 out_ch, out_data, out_last);
      end else begin
        w = exp_q.pop_front();
        if ({out_ch, out_data, out_last} !== w) begin
          n_fail++;
          $display("FAIL word: got ch=%0d data=%h last=%0b, expected ch=%0d data=%h last=%0b",
                   out_ch, out_data, out_last, w.ch, w.data, w.last);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int d, input bit last);
    word_t w;
    w.ch   = CHW'(ch);
    w.data = DW'(d);
    w.last = last;
    exp_q.push_back(w);
  endtask

  function automatic logic [N*DW-1:0] frm4(input int d0, input int d1,
                                           input int d2, input int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  task automatic do_arm(input logic [N-1:0] en, input logic mode,
                        input int k, input int len);
    cfg_ch_en    = en;
    cfg_mode     = mode;
    cfg_avg_log2 = KW'(k);
    cfg_cap_len  = CW'(len);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input logic [N*DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c = 0;
    @(negedge clk);
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_idle"}, busy, 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_in;
    int dcnt;
    rst = 1'b1; cfg_ch_en = '0; cfg_mode = 1'b0;
    cfg_avg_log2 = '0; cfg_cap_len = '0;
    arm = 0; trigger = 0; stop = 0; in_valid = 0;
    in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // 1: free-run passthrough, latency and ordering
    do_arm(4'hF, 1'b0, 0, 0);
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 4; c++)
        push(c, 'h100 + c, (f == 7) && (c == 3));
    t_in = cyc;
    for (int f = 0; f < 8; f++)
      send(frm4('h100, 'h101, 'h102, 'h103));
    do_stop();
    wait_done("t1", 200);
    chk("t1_latency", first_out_cyc - t_in, 2);
    chk("t1_overflow", overflow, 0);

    // 2: triggered, 4-frame average, 3 results
    do_arm(4'h1, 1'b1, 2, 3);
    tick();
    chk("t2_armed_busy", busy, 1);
    push(0, 1, 0);
    push(0, 5, 0);
    push(0, 9, 1);
    in_data = frm4(0, 0, 0, 0);
    trigger = 1'b1; in_valid = 1'b1;
    tick();
    trigger = 1'b0; in_valid = 1'b0;
    for (int v = 1; v <= 12; v++)
      send(frm4(v, 0, 0, 0));
    wait_done("t2", 100);

    // 3: long stall -> overflow, then ordered recovery
    out_ready = 1'b0;
    do_arm(4'hF, 1'b0, 0, 0);
    push(0, 'h800, 0);
    for (int r = 0; r < 16; r++) begin
      for (int c = 1; c < 4; c++)
        push(c, 'h800 | (c << 8) | r, 0);
      push(0, 'h800 | (r + 1), r == 15);
    end
    for (int f = 0; f < 40; f++) begin
      send(frm4('h800 | f, 'h900 | f, 'hA00 | f, 'hB00 | f));
      if (f == 5 || f == 20 || f == 39) begin
        chk("t3_stall_valid", out_valid, 1);
        chk("t3_stall_data", out_data, 'h800);
      end
    end
    do_stop();
    chk("t3_overflow", overflow, 4'hF);
    out_ready = 1'b1;
    wait_done("t3", 300);

    // 4: sparse enable mask
    do_arm(4'b0101, 1'b0, 0, 0);
    for (int f = 0; f < 6; f++) begin
      push(0, 'h100, 0);
      push(2, 'h102, f == 5);
    end
    for (int f = 0; f < 6; f++)
      send(frm4('h100, 'h101, 'h102, 'h103));
    do_stop();
    wait_done("t4", 100);
    chk("t4_overflow", overflow, 0);

    // 5: reset mid-capture, then clean restart
    out_ready = 1'b0;
    do_arm(4'hF, 1'b0, 0, 0);
    for (int f = 0; f < 20; f++)
      send(frm4(f, f, f, f));
    chk("t5_ovf_before_rst", overflow, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_overflow", overflow, 0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("t5_no_done", dcnt, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_arm(4'hF, 1'b0, 0, 0);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++)
        push(c, 'h100 + c, (f == 1) && (c == 3));
    for (int f = 0; f < 2; f++)
      send(frm4('h100, 'h101, 'h102, 'h103));
    do_stop();
    wait_done("t5", 100);

    // 6: empty enable mask
    do_arm(4'h0, 1'b0, 0, 0);
    @(negedge clk);
    chk("t6_busy_c1", busy, 1);
    @(negedge clk);
    chk("t6_busy_c2", busy, 1);
    chk("t6_no_done_c2", done, 0);
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_idle", busy, 0);
    chk("t6_no_word", out_valid, 0);
    @(negedge clk);
    chk("t6_done_pulse", done, 0);
    @(posedge clk); #1;

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
